// File: rtl/rc4_pkg.sv
// Shared RC4 types, sizes and key-byte extraction for the keystream engine.
// Pure declarations; no latency or backpressure of its own.
package rc4_pkg;

  localparam int RC4_WORD_W        = 8;
  localparam int RC4_N             = 256;
  localparam int RC4_KEY_MAX_BYTES = 32;
  localparam int RC4_KEY_MAX_W     = RC4_WORD_W * RC4_KEY_MAX_BYTES;

  typedef enum logic [2:0] {
    RC4_IDLE,
    RC4_INIT,
    RC4_KSA,
    RC4_DROP,
    RC4_GEN
  } rc4_state_t;

  // Key arrives left-aligned in a max-width vector, so byte 0 is always the top byte.
  function automatic logic [RC4_WORD_W-1:0] key_byte(input logic [RC4_KEY_MAX_W-1:0] key,
                                                     input int idx);
    logic [RC4_KEY_MAX_W-1:0] sh;
    sh = key << (RC4_WORD_W * idx);
    return sh[RC4_KEY_MAX_W-1 -: RC4_WORD_W];
  endfunction

endpackage

// File: rtl/rc4_state_regfile.sv
// 256x8 RC4 permutation array: three combinational reads, swap pair write, init write.
// Reads are zero-latency; the t port sees this cycle's swap; no backpressure.
module rc4_state_regfile
  import rc4_pkg::*;
(
  input  logic                  clk,
  input  logic                  init_we,
  input  logic [RC4_WORD_W-1:0] init_addr,
  input  logic [RC4_WORD_W-1:0] init_data,
  input  logic                  swap_we,
  input  logic [RC4_WORD_W-1:0] wr0_addr,
  input  logic [RC4_WORD_W-1:0] wr0_data,
  input  logic [RC4_WORD_W-1:0] wr1_addr,
  input  logic [RC4_WORD_W-1:0] wr1_data,
  input  logic [RC4_WORD_W-1:0] rd_a_addr,
  output logic [RC4_WORD_W-1:0] rd_a_data,
  input  logic [RC4_WORD_W-1:0] rd_b_addr,
  output logic [RC4_WORD_W-1:0] rd_b_data,
  input  logic [RC4_WORD_W-1:0] rd_t_addr,
  output logic [RC4_WORD_W-1:0] rd_t_data
);

  logic [RC4_WORD_W-1:0] mem [RC4_N];

  assign rd_a_data = mem[rd_a_addr];
  assign rd_b_data = mem[rd_b_addr];

  // When both swap addresses coincide the two write values are equal, so order is irrelevant.
  always_comb begin
    rd_t_data = mem[rd_t_addr];
    if (swap_we && (rd_t_addr == wr1_addr)) begin
      rd_t_data = wr1_data;
    end else if (swap_we && (rd_t_addr == wr0_addr)) begin
      rd_t_data = wr0_data;
    end
  end

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end
    if (swap_we) begin
      mem[wr0_addr] <= wr0_data;
      mem[wr1_addr] <= wr1_data;
    end
  end

endmodule

// File: rtl/rc4_keystream_engine.sv
// RC4(-dropN) keystream generator: INIT, KSA, optional drop, then one byte per cycle.
// First byte 513+DROP edges after start; GEN holds i/j/S/data while valid && !ready.
module rc4_keystream_engine
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 4,
  parameter int DROP      = 0
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [8*KEY_BYTES-1:0] key_i,
  input  logic                   ks_ready_i,
  output logic                   ks_valid_o,
  output logic [7:0]             ks_data_o,
  output logic                   busy_o
);

  localparam int KEY_W  = RC4_WORD_W * KEY_BYTES;
  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int DROP_W = 11;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
  localparam logic [DROP_W-1:0] DROP_LAST = DROP_W'((DROP > 0) ? DROP - 1 : 0);

  rc4_state_t state_q, state_d;

  logic [RC4_WORD_W-1:0] i_q, j_q;
  logic [KIDX_W-1:0]     kidx_q;
  logic [DROP_W-1:0]     drop_q;
  logic [KEY_W-1:0]      key_q;

  logic [RC4_WORD_W-1:0] idx_a, s_a, j_nx, s_b, t_idx, s_t, k_byte;
  logic                  step_fire, swap_we, init_we, in_ksa;

  assign in_ksa = (state_q == RC4_KSA);
  assign k_byte = key_byte(RC4_KEY_MAX_W'(key_q) << (RC4_KEY_MAX_W - KEY_W), int'(kidx_q));

  // KSA swaps at i; DROP/GEN pre-increment i and swap at i+1.
  assign idx_a = in_ksa ? i_q : i_q + 8'd1;
  assign j_nx  = in_ksa ? j_q + s_a + k_byte : j_q + s_a;
  assign t_idx = s_a + s_b;

  assign step_fire = (state_q == RC4_DROP) ||
                     ((state_q == RC4_GEN) && (!ks_valid_o || ks_ready_i));
  assign swap_we   = !abort_i && (in_ksa || step_fire);
  assign init_we   = !abort_i && (state_q == RC4_INIT);

  assign busy_o = (state_q == RC4_INIT) || (state_q == RC4_KSA) || (state_q == RC4_DROP);

  rc4_state_regfile u_sbox (
    .clk       (clk),
    .init_we   (init_we),
    .init_addr (i_q),
    .init_data (i_q),
    .swap_we   (swap_we),
    .wr0_addr  (idx_a),
    .wr0_data  (s_b),
    .wr1_addr  (j_nx),
    .wr1_data  (s_a),
    .rd_a_addr (idx_a),
    .rd_a_data (s_a),
    .rd_b_addr (j_nx),
    .rd_b_data (s_b),
    .rd_t_addr (t_idx),
    .rd_t_data (s_t)
  );

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = RC4_IDLE;
    end else begin
      case (state_q)
        RC4_IDLE: if (start_i) state_d = RC4_INIT;
        RC4_INIT: if (i_q == 8'hFF) state_d = RC4_KSA;
        RC4_KSA:  if (i_q == 8'hFF) state_d = (DROP > 0) ? RC4_DROP : RC4_GEN;
        RC4_DROP: if (drop_q == DROP_LAST) state_d = RC4_GEN;
        RC4_GEN:  state_d = RC4_GEN;
        default:  state_d = RC4_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= RC4_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!abort_i && (state_q == RC4_IDLE) && start_i) begin
      key_q <= key_i;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      i_q        <= '0;
      j_q        <= '0;
      kidx_q     <= '0;
      drop_q     <= '0;
      ks_valid_o <= 1'b0;
      ks_data_o  <= 8'h00;
    end else if (abort_i) begin
      i_q        <= '0;
      j_q        <= '0;
      kidx_q     <= '0;
      drop_q     <= '0;
      ks_valid_o <= 1'b0;
    end else begin
      case (state_q)
        RC4_IDLE: begin
          if (start_i) begin
            i_q    <= '0;
            j_q    <= '0;
            kidx_q <= '0;
            drop_q <= '0;
          end
        end
        RC4_INIT: begin
          i_q    <= i_q + 8'd1;
          j_q    <= '0;
          kidx_q <= '0;
        end
        RC4_KSA: begin
          i_q    <= i_q + 8'd1;
          j_q    <= (i_q == 8'hFF) ? 8'h00 : j_nx;
          kidx_q <= (kidx_q == KIDX_LAST) ? '0 : kidx_q + KIDX_W'(1);
        end
        RC4_DROP: begin
          i_q    <= idx_a;
          j_q    <= j_nx;
          drop_q <= drop_q + DROP_W'(1);
        end
        RC4_GEN: begin
          if (step_fire) begin
            i_q        <= idx_a;
            j_q        <= j_nx;
            ks_data_o  <= s_t;
            ks_valid_o <= 1'b1;
          end
        end
        default: begin
          i_q <= '0;
          j_q <= '0;
        end
      endcase
    end
  end

endmodule
